mem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port, fixed-latency data memory.
- Port 0 is instruction fetch and port 1 is the load/store unit.
- Grants one access at a time using round-robin priority.
- Holds the memory command stable for MEM_LATENCY cycles, captures read data, then returns a one-cycle ready pulse to the granted requester.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 23 ++
 rtl/mem_arb_rr2.sv | 21 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port indices also serve as bit positions in the one-hot grant vector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_LSU    = 1;

  // Width of the access-cycle counter; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's view of the shared memory.
// The requester drives the command; the arbiter returns read data and a done pulse.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last_grant,
  output logic [1:0] o_winner
);

  logic w_pick_lsu;

  assign w_pick_lsu = i_req1 && (!i_req0 || (i_last_grant == 1'b0));

  always_comb begin
    o_winner              = 2'b00;
    o_winner[PORT_IFETCH] = i_req0 && !w_pick_lsu;
    o_winner[PORT_LSU]    = w_pick_lsu;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port fixed-latency memory, holding each
// command for MEM_LATENCY cycles and pulsing ready to the owner afterwards.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 10,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_arbiter_if.slave          port0,
  mem_arbiter_if.slave          port1,
  output logic [1:0]            grant,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int              CNT_W      = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MEM_LATENCY - 1);

  state_t                r_state;
  logic [1:0]            r_grant;
  logic                  r_last_grant;
  logic [CNT_W-1:0]      r_count;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_write_data;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_ready0;
  logic                  r_ready1;

  logic [1:0]            w_winner;
  logic                  w_sel_lsu;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  mem_arb_rr2 u_rr2 (
    .i_req0       (port0.req),
    .i_req1       (port1.req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );

  assign w_sel_lsu   = w_winner[PORT_LSU];
  assign w_sel_we    = w_sel_lsu ? port1.we    : port0.we;
  assign w_sel_addr  = w_sel_lsu ? port1.addr  : port0.addr;
  assign w_sel_wdata = w_sel_lsu ? port1.wdata : port0.wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= IDLE;
      r_grant          <= 2'b00;
      r_last_grant     <= 1'b1;
      r_count          <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_rdata0         <= '0;
      r_rdata1         <= '0;
      r_ready0         <= 1'b0;
      r_ready1         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_winner != 2'b00) begin
            r_grant          <= w_winner;
            r_last_grant     <= w_sel_lsu;
            r_count          <= '0;
            r_mem_read       <= ~w_sel_we;
            r_mem_write      <= w_sel_we;
            r_mem_address    <= w_sel_addr;
            r_mem_write_data <= w_sel_wdata;
            r_state          <= ACCESS;
          end
        end
        ACCESS: begin
          r_count <= r_count + 1'b1;
          if (r_count == LAST_COUNT) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ready0    <= r_grant[PORT_IFETCH];
            r_ready1    <= r_grant[PORT_LSU];
            // Writes leave the requester's last read value untouched.
            if (!r_mem_write) begin
              if (r_grant[PORT_IFETCH]) r_rdata0 <= mem_read_data;
              if (r_grant[PORT_LSU])    r_rdata1 <= mem_read_data;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_grant  <= 2'b00;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant          = r_grant;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign port0.rdata    = r_rdata0;
  assign port0.ready    = r_ready0;
  assign port1.rdata    = r_rdata1;
  assign port1.ready    = r_ready1;

endmodule
